// File: rtl/int_sequencer.sv
// Machine-mode trap sequencer.
//
// Watches the decode stage for ECALL/EBREAK/MRET and the external interrupt
// lines. When an event is taken it stalls the pipeline and writes
// mepc/mcause/mstatus (or only mstatus for MRET) in a fixed order. It then
// issues a one-cycle redirect strobe with the target address.
//
// Ports:
//   clk, rst       core clock, synchronous active-high reset
//   inst_i         instruction in decode
//   inst_addr_i    address of inst_i
//   jump_flag_i    execute stage is redirecting this cycle
//   jump_addr_i    execute redirect target
//   irq_i          level-sensitive external interrupt requests
//   csr_mtvec_i    current mtvec
//   csr_mepc_i     current mepc
//   csr_mstatus_i  current mstatus (bit 3 MIE, bit 7 MPIE)
//   hold_o         pipeline hold request
//   csr_we_o       CSR write enable (registered)
//   csr_waddr_o    CSR write address (registered)
//   csr_wdata_o    CSR write data (registered)
//   int_assert_o   one-cycle redirect strobe (registered)
//   int_addr_o     redirect target, valid with int_assert_o (registered, held)
module int_sequencer #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] inst_i,
    input  logic [DATA_W-1:0] inst_addr_i,
    input  logic              jump_flag_i,
    input  logic [DATA_W-1:0] jump_addr_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [DATA_W-1:0] csr_mtvec_i,
    input  logic [DATA_W-1:0] csr_mepc_i,
    input  logic [DATA_W-1:0] csr_mstatus_i,
    output logic              hold_o,
    output logic              csr_we_o,
    output logic [11:0]       csr_waddr_o,
    output logic [DATA_W-1:0] csr_wdata_o,
    output logic              int_assert_o,
    output logic [DATA_W-1:0] int_addr_o
);

    localparam logic [DATA_W-1:0] InstEcall  = DATA_W'(32'h0000_0073);
    localparam logic [DATA_W-1:0] InstEbreak = DATA_W'(32'h0010_0073);
    localparam logic [DATA_W-1:0] InstMret   = DATA_W'(32'h3020_0073);

    localparam logic [11:0] CsrMstatus = 12'h300;
    localparam logic [11:0] CsrMepc    = 12'h341;
    localparam logic [11:0] CsrMcause  = 12'h342;

    localparam logic [DATA_W-1:0] CauseEcall  = DATA_W'(11);
    localparam logic [DATA_W-1:0] CauseEbreak = DATA_W'(3);
    localparam logic [DATA_W-1:0] CauseIntBit = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        StIdle         = 3'd0,
        StWMepc        = 3'd1,
        StWMcause      = 3'd2,
        StWMstatus     = 3'd3,
        StAssert       = 3'd4,
        StWMstatusMret = 3'd5,
        StMretAssert   = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] epc_q, epc_d;
    logic [DATA_W-1:0] cause_q, cause_d;
    logic              csr_we_q, csr_we_d;
    logic [11:0]       csr_waddr_q, csr_waddr_d;
    logic [DATA_W-1:0] csr_wdata_q, csr_wdata_d;
    logic              int_assert_q, int_assert_d;
    logic [DATA_W-1:0] int_addr_q, int_addr_d;

    logic              is_ecall, is_ebreak, is_mret, is_sync, irq_take, any_event;
    logic [4:0]        irq_idx;
    logic [DATA_W-1:0] mstatus_trap, mstatus_mret;

    // Event decode
    assign is_ecall  = (inst_i == InstEcall);
    assign is_ebreak = (inst_i == InstEbreak);
    assign is_mret   = (inst_i == InstMret);
    assign is_sync   = is_ecall | is_ebreak;
    assign irq_take  = (|irq_i) & csr_mstatus_i[3];
    assign any_event = is_sync | irq_take | is_mret;

    // Lowest set interrupt line wins; scanning downward lets the lowest
    // index overwrite any higher one.
    always_comb begin
        irq_idx = 5'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_i[i]) begin
                irq_idx = 5'(i);
            end
        end
    end

    // mstatus images for trap entry and MRET
    always_comb begin
        mstatus_trap    = csr_mstatus_i;
        mstatus_trap[7] = csr_mstatus_i[3];
        mstatus_trap[3] = 1'b0;

        mstatus_mret    = csr_mstatus_i;
        mstatus_mret[3] = csr_mstatus_i[7];
        mstatus_mret[7] = 1'b1;
    end

    // Next state and captured epc/cause
    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        cause_d = cause_q;

        case (state_q)
            StIdle: begin
                if (is_sync) begin
                    epc_d   = inst_addr_i;
                    cause_d = is_ecall ? CauseEcall : CauseEbreak;
                    state_d = StWMepc;
                end else if (irq_take) begin
                    // A redirect in flight is the next instruction that would run.
                    epc_d   = jump_flag_i ? jump_addr_i : inst_addr_i;
                    cause_d = CauseIntBit | DATA_W'(5'd16 + irq_idx);
                    state_d = StWMepc;
                end else if (is_mret) begin
                    state_d = StWMstatusMret;
                end
            end
            StWMepc:        state_d = StWMcause;
            StWMcause:      state_d = StWMstatus;
            StWMstatus:     state_d = StAssert;
            StAssert:       state_d = StIdle;
            StWMstatusMret: state_d = StMretAssert;
            StMretAssert:   state_d = StIdle;
            default:        state_d = StIdle;
        endcase
    end

    // Outputs are registered, so they are derived from the state being
    // entered; this places each write in the cycle of its named state.
    always_comb begin
        csr_we_d     = 1'b0;
        csr_waddr_d  = 12'h000;
        csr_wdata_d  = '0;
        int_assert_d = 1'b0;
        int_addr_d   = int_addr_q;

        case (state_d)
            StWMepc: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = CsrMepc;
                csr_wdata_d = epc_d;
            end
            StWMcause: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = CsrMcause;
                csr_wdata_d = cause_q;
            end
            StWMstatus: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = CsrMstatus;
                csr_wdata_d = mstatus_trap;
            end
            StAssert: begin
                int_assert_d = 1'b1;
                int_addr_d   = csr_mtvec_i;
            end
            StWMstatusMret: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = CsrMstatus;
                csr_wdata_d = mstatus_mret;
            end
            StMretAssert: begin
                int_assert_d = 1'b1;
                int_addr_d   = csr_mepc_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            epc_q        <= '0;
            cause_q      <= '0;
            csr_we_q     <= 1'b0;
            csr_waddr_q  <= 12'h000;
            csr_wdata_q  <= '0;
            int_assert_q <= 1'b0;
            int_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            epc_q        <= epc_d;
            cause_q      <= cause_d;
            csr_we_q     <= csr_we_d;
            csr_waddr_q  <= csr_waddr_d;
            csr_wdata_q  <= csr_wdata_d;
            int_assert_q <= int_assert_d;
            int_addr_q   <= int_addr_d;
        end
    end

    // Hold covers the detect cycle and every sequencing state except the
    // redirect cycle itself; suppressed while reset is applied.
    always_comb begin
        hold_o = 1'b0;
        if (!rst) begin
            case (state_q)
                StIdle:                 hold_o = any_event;
                StAssert, StMretAssert: hold_o = 1'b0;
                default:                hold_o = 1'b1;
            endcase
        end
    end

    assign csr_we_o     = csr_we_q;
    assign csr_waddr_o  = csr_waddr_q;
    assign csr_wdata_o  = csr_wdata_q;
    assign int_assert_o = int_assert_q;
    assign int_addr_o   = int_addr_q;

endmodule

// File: tb/tb_int_sequencer.sv
module tb_int_sequencer;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned NUM_IRQ = 8;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] inst_i;
    logic [DATA_W-1:0] inst_addr_i;
    logic              jump_flag_i;
    logic [DATA_W-1:0] jump_addr_i;
    logic [NUM_IRQ-1:0] irq_i;
    logic [DATA_W-1:0] csr_mtvec_i;
    logic [DATA_W-1:0] csr_mepc_i;
    logic [DATA_W-1:0] csr_mstatus_i;
    logic              hold_o;
    logic              csr_we_o;
    logic [11:0]       csr_waddr_o;
    logic [DATA_W-1:0] csr_wdata_o;
    logic              int_assert_o;
    logic [DATA_W-1:0] int_addr_o;

    int checks = 0;
    int errors = 0;

    int_sequencer #(
        .DATA_W (DATA_W),
        .NUM_IRQ(NUM_IRQ)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_i       (inst_i),
        .inst_addr_i  (inst_addr_i),
        .jump_flag_i  (jump_flag_i),
        .jump_addr_i  (jump_addr_i),
        .irq_i        (irq_i),
        .csr_mtvec_i  (csr_mtvec_i),
        .csr_mepc_i   (csr_mepc_i),
        .csr_mstatus_i(csr_mstatus_i),
        .hold_o       (hold_o),
        .csr_we_o     (csr_we_o),
        .csr_waddr_o  (csr_waddr_o),
        .csr_wdata_o  (csr_wdata_o),
        .int_assert_o (int_assert_o),
        .int_addr_o   (int_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Settle after driving inputs, before sampling.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        inst_i        = NOP;
        inst_addr_i   = 32'h0;
        jump_flag_i   = 1'b0;
        jump_addr_i   = 32'h0;
        irq_i         = '0;
        csr_mtvec_i   = 32'h80;
        csr_mepc_i    = 32'h104;
        csr_mstatus_i = 32'h08;

        // Reset state
        next_cycle();
        next_cycle();
        settle();
        check("rst_we", csr_we_o, 0);
        check("rst_waddr", csr_waddr_o, 0);
        check("rst_wdata", csr_wdata_o, 0);
        check("rst_assert", int_assert_o, 0);
        check("rst_addr", int_addr_o, 0);
        check("rst_hold", hold_o, 0);

        next_cycle();
        rst = 1'b0;
        settle();
        check("idle_hold", hold_o, 0);

        // ECALL at 0x100, mtvec 0x80
        next_cycle();
        inst_i = ECALL; inst_addr_i = 32'h100;
        settle();
        check("ecall_n_hold", hold_o, 1);
        check("ecall_n_we", csr_we_o, 0);
        next_cycle();
        inst_i = NOP;
        settle();
        check("ecall_mepc_we", csr_we_o, 1);
        check("ecall_mepc_addr", csr_waddr_o, 32'h341);
        check("ecall_mepc_data", csr_wdata_o, 32'h100);
        check("ecall_n1_hold", hold_o, 1);
        next_cycle();
        settle();
        check("ecall_mcause_we", csr_we_o, 1);
        check("ecall_mcause_addr", csr_waddr_o, 32'h342);
        check("ecall_mcause_data", csr_wdata_o, 32'd11);
        check("ecall_n2_hold", hold_o, 1);
        next_cycle();
        settle();
        check("ecall_mstatus_we", csr_we_o, 1);
        check("ecall_mstatus_addr", csr_waddr_o, 32'h300);
        check("ecall_mstatus_data", csr_wdata_o, 32'h80);
        check("ecall_n3_hold", hold_o, 1);
        next_cycle();
        csr_mstatus_i = 32'h80;
        settle();
        check("ecall_assert", int_assert_o, 1);
        check("ecall_target", int_addr_o, 32'h80);
        check("ecall_n4_hold", hold_o, 0);
        check("ecall_n4_we", csr_we_o, 0);
        next_cycle();
        settle();
        check("ecall_assert_width", int_assert_o, 0);
        check("ecall_addr_held", int_addr_o, 32'h80);
        check("ecall_n5_hold", hold_o, 0);

        // MRET with mstatus 0x80, mepc 0x104
        next_cycle();
        inst_i = MRET; inst_addr_i = 32'h108;
        settle();
        check("mret_n_hold", hold_o, 1);
        next_cycle();
        inst_i = NOP;
        settle();
        check("mret_we", csr_we_o, 1);
        check("mret_addr", csr_waddr_o, 32'h300);
        check("mret_data", csr_wdata_o, 32'h88);
        check("mret_n1_hold", hold_o, 1);
        next_cycle();
        csr_mstatus_i = 32'h88;
        settle();
        check("mret_assert", int_assert_o, 1);
        check("mret_target", int_addr_o, 32'h104);
        check("mret_n2_hold", hold_o, 0);
        check("mret_n2_we", csr_we_o, 0);
        next_cycle();
        settle();
        check("mret_assert_width", int_assert_o, 0);

        // irq line 2 with redirect in flight, MIE = 1
        next_cycle();
        irq_i = 8'b0000_0100; jump_flag_i = 1'b1; jump_addr_i = 32'h200;
        inst_addr_i = 32'h120;
        settle();
        check("irq_n_hold", hold_o, 1);
        next_cycle();
        jump_flag_i = 1'b0;
        settle();
        check("irq_mepc_addr", csr_waddr_o, 32'h341);
        check("irq_mepc_data", csr_wdata_o, 32'h200);
        next_cycle();
        settle();
        check("irq_mcause_addr", csr_waddr_o, 32'h342);
        check("irq_mcause_data", csr_wdata_o, 32'h8000_0012);
        next_cycle();
        settle();
        check("irq_mstatus_data", csr_wdata_o, 32'h80);
        next_cycle();
        csr_mstatus_i = 32'h80;
        settle();
        check("irq_assert", int_assert_o, 1);
        // irq still high but MIE = 0: no response
        next_cycle();
        settle();
        check("irq_mie0_hold", hold_o, 0);
        check("irq_mie0_we", csr_we_o, 0);
        check("irq_mie0_assert", int_assert_o, 0);
        next_cycle();
        jump_flag_i = 1'b1;
        settle();
        check("irq_mie0_hold2", hold_o, 0);
        check("irq_mie0_we2", csr_we_o, 0);
        next_cycle();
        irq_i = '0; jump_flag_i = 1'b0;
        settle();

        // EBREAK together with irq 0, MIE = 1: sync wins
        next_cycle();
        csr_mstatus_i = 32'h08;
        inst_i = EBREAK; inst_addr_i = 32'h140; irq_i = 8'h01;
        settle();
        check("ebrk_n_hold", hold_o, 1);
        next_cycle();
        inst_i = NOP; irq_i = '0;
        settle();
        check("ebrk_mepc_data", csr_wdata_o, 32'h140);
        next_cycle();
        settle();
        check("ebrk_mcause_data", csr_wdata_o, 32'd3);
        next_cycle();
        settle();
        check("ebrk_mstatus_data", csr_wdata_o, 32'h80);
        next_cycle();
        csr_mstatus_i = 32'h80;
        settle();
        check("ebrk_assert", int_assert_o, 1);
        next_cycle();
        settle();
        check("ebrk_idle_hold", hold_o, 0);

        // irq 0 drops during W_MCAUSE: one sequence only
        next_cycle();
        csr_mstatus_i = 32'h08;
        irq_i = 8'h01; inst_addr_i = 32'h160;
        settle();
        check("tog_n_hold", hold_o, 1);
        next_cycle();
        settle();
        check("tog_mepc_data", csr_wdata_o, 32'h160);
        next_cycle();
        irq_i = '0;
        settle();
        check("tog_mcause_data", csr_wdata_o, 32'h8000_0010);
        next_cycle();
        settle();
        check("tog_mstatus_data", csr_wdata_o, 32'h80);
        next_cycle();
        csr_mstatus_i = 32'h80;
        settle();
        check("tog_assert", int_assert_o, 1);
        next_cycle();
        settle();
        check("tog_after_hold", hold_o, 0);
        check("tog_after_we", csr_we_o, 0);
        check("tog_after_assert", int_assert_o, 0);
        next_cycle();
        settle();
        check("tog_after2_we", csr_we_o, 0);
        check("tog_after2_assert", int_assert_o, 0);

        // Reset during W_MCAUSE
        next_cycle();
        csr_mstatus_i = 32'h08;
        inst_i = ECALL; inst_addr_i = 32'h180;
        settle();
        check("rstm_n_hold", hold_o, 1);
        next_cycle();
        inst_i = NOP;
        settle();
        check("rstm_mepc_data", csr_wdata_o, 32'h180);
        next_cycle();
        rst = 1'b1;
        settle();
        check("rstm_mcause_addr", csr_waddr_o, 32'h342);
        next_cycle();
        rst = 1'b0;
        settle();
        check("rstm_we", csr_we_o, 0);
        check("rstm_waddr", csr_waddr_o, 0);
        check("rstm_assert", int_assert_o, 0);
        check("rstm_hold", hold_o, 0);
        next_cycle();
        settle();
        check("rstm_no_mstatus_we", csr_we_o, 0);
        check("rstm_no_assert", int_assert_o, 0);
        next_cycle();
        settle();
        check("rstm_no_assert2", int_assert_o, 0);
        check("rstm_idle_hold", hold_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/int_sequencer.md
Name: int_sequencer

Overview:
- Machine-mode trap sequencer for the pipelined core.
- Detects synchronous exceptions (ECALL/EBREAK), asynchronous external interrupts and MRET presented at decode.
- Stalls the pipeline, writes mepc/mcause/mstatus into the CSR file in a fixed multi-cycle sequence, then issues a one-cycle redirect (int_assert_o, int_addr_o) to the pipeline controller and PC.

Parameters:
- DATA_W, 32, width of instruction, address and CSR data buses.
- NUM_IRQ, 8, number of external interrupt lines (1..16).

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous, active-high reset.
- inst_i  input  DATA_W  instruction currently in decode.
- inst_addr_i  input  DATA_W  address of inst_i.
- jump_flag_i  input  1  execute stage is redirecting this cycle.
- jump_addr_i  input  DATA_W  execute redirect target.
- irq_i  input  NUM_IRQ  level-sensitive external interrupt requests.
- csr_mtvec_i  input  DATA_W  current mtvec.
- csr_mepc_i  input  DATA_W  current mepc.
- csr_mstatus_i  input  DATA_W  current mstatus; bit3 = MIE, bit7 = MPIE.
- hold_o  output  1  pipeline hold request to the controller.
- csr_we_o  output  1  CSR write enable.
- csr_waddr_o  output  12  CSR write address.
- csr_wdata_o  output  DATA_W  CSR write data.
- int_assert_o  output  1  one-cycle trap/return redirect strobe.
- int_addr_o  output  DATA_W  redirect target, valid with int_assert_o.

Behaviour:
- Reset (synchronous, active-high): state = IDLE; csr_we_o = 0, csr_waddr_o = 0, csr_wdata_o = 0, int_assert_o = 0, int_addr_o = 0, hold_o = 0; epc/cause registers = 0.
- Decode encodings: ECALL 32'h0000_0073, EBREAK 32'h0010_0073, MRET 32'h3020_0073.
- CSR addresses: mstatus 12'h300, mepc 12'h341, mcause 12'h342.
- IDLE event priority: sync exception > async interrupt > MRET.
  - Sync exception (ECALL or EBREAK in inst_i): epc <= inst_addr_i; cause <= 11 for ECALL, 3 for EBREAK; next state W_MEPC.
  - Async interrupt (irq_i != 0 and mstatus.MIE = 1): epc <= jump_flag_i ? jump_addr_i : inst_addr_i; cause <= 32'h8000_0000 | (16 + k), where k is the lowest set irq bit; next state W_MEPC.
  - MRET: next state W_MSTATUS_MRET.
  - No event: remain in IDLE.
- hold_o:
  - Combinational 1 in IDLE in the cycle any event is detected.
  - 1 in every non-IDLE state except ASSERT and MRET_ASSERT.
  - 0 otherwise.
- CSR writes: csr_we_o, csr_waddr_o and csr_wdata_o are registered and driven during the named state; csr_we_o = 0 in all other states.
  - W_MEPC: addr 12'h341, data epc; next W_MCAUSE.
  - W_MCAUSE: addr 12'h342, data cause; next W_MSTATUS.
  - W_MSTATUS: addr 12'h300, data = mstatus with MPIE <= MIE and MIE <= 0; next ASSERT.
  - ASSERT: int_assert_o = 1, int_addr_o = csr_mtvec_i; next IDLE.
  - W_MSTATUS_MRET: addr 12'h300, data = mstatus with MIE <= MPIE and MPIE <= 1; next MRET_ASSERT.
  - MRET_ASSERT: int_assert_o = 1, int_addr_o = csr_mepc_i; next IDLE.
- Latency, with the event detected in cycle N:
  - Trap: mepc written at N+1, mcause at N+2, mstatus at N+3, int_assert_o at N+4.
  - MRET: mstatus written at N+1, int_assert_o at N+2.
- int_assert_o is exactly one cycle wide; int_addr_o is held at its last value otherwise.
- irq_i is sampled only in IDLE. Requests arriving mid-sequence are not latched; they are re-evaluated on return to IDLE.
- The CSR file makes writes visible the following cycle, so MIE = 0 is seen in IDLE after ASSERT and no re-trigger occurs.
- An ECALL coinciding with an active irq takes the sync path. The interrupt is taken later if MIE is re-enabled.
- Asserting rst mid-sequence returns to IDLE next cycle with all outputs cleared; CSR writes already performed are not undone.
- Illegal or unused state encodings go to IDLE.

Test Plan:
- ECALL at inst_addr_i = 32'h100, mtvec = 32'h80: mepc <= 32'h100 at N+1, mcause <= 11 at N+2, mstatus 32'h08 -> 32'h80 at N+3, int_assert_o with int_addr_o = 32'h80 at N+4; hold_o high N..N+3.
- irq_i = 8'b0000_0100, MIE = 1, jump_flag_i = 1, jump_addr_i = 32'h200: mepc <= 32'h200, mcause <= 32'h8000_0012. With MIE = 0, the same stimulus gives no response.
- MRET with mstatus = 32'h80, mepc = 32'h104: mstatus <= 32'h88 at N+1, int_assert_o with int_addr_o = 32'h104 at N+2.
- EBREAK and irq_i = 8'h01 together with MIE = 1: mcause = 3 (sync wins).
- irq_i toggles 1 -> 0 during W_MCAUSE: no second trap. The sequence completes exactly once.
- rst asserted in W_MCAUSE: next cycle state IDLE, csr_we_o = 0, int_assert_o = 0, hold_o = 0; no mstatus write occurs.
